sdram_rw_arbiter: RTL and testbench
===================================

Name: sdram_rw_arbiter

Overview:
- Shares the single bidirectional SDRAM wrapper command port (rw_addr/rw_cnt/read_start/write_start/rw_done plus read and write data streams) between NUM_REQ NPU-side requesters, for example an activation loader and a result writeback unit.
- Performs round-robin arbitration, holds the granted command stable for the whole burst, and routes the data streams to and from the owning requester only.
- Sits between the NPU core and avmm_sdram_wrapper inside the FPGA fabric.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- SDRAM_W, 128, data beat width in bits.
- CNT_W, 11, burst beat count width; matches the wrapper rw_cnt.
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester command request; held until req_grant.
- req_write  in  NUM_REQ  per-requester direction: 1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  per-requester start address (slice i = requester i).
- req_cnt  in  NUM_REQ*CNT_W  per-requester beat count.
- req_grant  out  NUM_REQ  one-hot, 1-cycle pulse when the command is accepted.
- req_done  out  NUM_REQ  one-hot, 1-cycle pulse when the burst completes.
- req_rd_valid  out  NUM_REQ  read beat valid, asserted to the owner only.
- req_rd_data  out  SDRAM_W  read beat, broadcast to all requesters.
- req_wr_nxt  out  NUM_REQ  write beat consumed, asserted to the owner only.
- req_wr_data  in  NUM_REQ*SDRAM_W  per-requester write beat.
- rw_addr  out  ADDR_W  to wrapper.
- rw_cnt  out  CNT_W  to wrapper.
- read_start  out  1  to wrapper, 1-cycle pulse.
- write_start  out  1  to wrapper, 1-cycle pulse.
- rw_done  in  1  from wrapper, 1-cycle completion pulse.
- read_valid  in  1  from wrapper.
- read_data  in  SDRAM_W  from wrapper.
- write_nxt  in  1  from wrapper.
- write_data  out  SDRAM_W  to wrapper.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE, rr_ptr = 0, owner = 0.
  - All outputs are 0: req_grant, req_done, req_rd_valid, req_wr_nxt, read_start, write_start, rw_addr, rw_cnt, write_data.
  - The wrapper shares rst_n, so a reset mid-burst aborts both blocks cleanly. No pending state survives reset.
- FSM states: IDLE, ISSUE, BUSY, DONE.
- IDLE:
  - If any req_valid is high, select the first requester at or after rr_ptr, wrapping modulo NUM_REQ.
  - Latch owner, addr, cnt and dir into registers, and pulse req_grant[owner].
  - If cnt == 0, go to DONE without starting the wrapper; otherwise go to ISSUE.
- ISSUE:
  - Assert read_start or write_start for exactly 1 cycle according to the latched dir, then go to BUSY.
  - Latency is 1 cycle from req_valid sampled in IDLE to the start pulse.
- BUSY:
  - rw_addr and rw_cnt are driven from the latched registers and stay stable from ISSUE until rw_done.
  - Read direction: req_rd_valid[owner] = read_valid (combinational pass-through); req_rd_data = read_data.
  - Write direction: write_data = req_wr_data[owner] (combinational mux); req_wr_nxt[owner] = write_nxt.
  - On rw_done, go to DONE.
- DONE:
  - Pulse req_done[owner] and set rr_ptr = (owner+1) mod NUM_REQ, then return to IDLE.
  - Minimum gap between the done pulse and the next start pulse is 2 cycles (DONE, IDLE, ISSUE).
- Data routing rules:
  - req_rd_valid and req_wr_nxt for non-owners are always 0.
  - Outside BUSY, all routed strobes are 0.
  - read_valid or write_nxt arriving outside BUSY is ignored. write_nxt during a read burst is ignored, and likewise read_valid during a write burst.
- Request and completion rules:
  - req_valid changes while a request is waiting or while another burst is BUSY are ignored until the next IDLE sample.
  - The request is consumed at req_grant; the requester must not reassert req_valid for a new command before its req_done.
  - An rw_done received in IDLE or ISSUE is ignored, since the wrapper protocol forbids it.
  - Simultaneous requests are resolved strictly by rr_ptr; a requester waits at most NUM_REQ-1 bursts.

Decomposition:
- Package sdram_arb_pkg:
  - typedef arb_state_e {IDLE, ISSUE, BUSY, DONE}.
  - typedef rw_cmd_t {addr, cnt, write}.
  - Constants DIR_READ and DIR_WRITE.
- Sub-module rr_arbiter: combinational round-robin pick taking req vector and rr_ptr, producing a one-hot grant and its index. It is reusable for a future read-only-port arbiter.

Test Plan:
1. Single read: requester 0 issues addr 0x3000_0000, cnt 4; BFM returns 4 beats 0xA0..0xA3 -> grant[0] pulses, read_start 1 cycle later, rw_addr/rw_cnt stable, req_rd_valid[0] high 4 cycles with matching data, req_rd_valid[1] always 0, req_done[0] 1 cycle after rw_done.
2. Single write: requester 1 issues addr 0x3000_0400, cnt 3 with data 0xB0..0xB2 -> write_start pulses, write_data follows req_wr_data slice 1, req_wr_nxt[1] mirrors write_nxt 3 times, the memory dump holds 0xB0..0xB2.
3. Contention: both requesters raise req_valid in the same cycle from reset, then again after each done -> grant order 0,1,0,1; no start pulse while BUSY; start pulses at least 2 cycles after rw_done.
4. Zero count: requester 0 issues cnt 0 -> grant and done pulse, no read_start or write_start, rr_ptr advances to 1.
5. Reset mid-burst: rst_n dropped during BUSY at beat 2 of 8 -> all outputs 0 immediately; after release, a new request from requester 1 is served normally from IDLE.
6. Stray strobes: inject read_valid during a write burst and write_nxt in IDLE -> no req_rd_valid or req_wr_nxt asserted, and the FSM state is unchanged.

Source files
------------

// File: rtl/sdram_rw_arbiter_pkg.sv
// sdram_arb_pkg: shared states, command record and direction codes for the SDRAM port arbiter
package sdram_arb_pkg;
    localparam int ARB_ADDR_W = 32;
    localparam int ARB_CNT_W  = 11;
    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;
    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} arb_state_e;
    typedef struct packed {
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_CNT_W-1:0]  cnt;
        logic                  write;
    } rw_cmd_t;
endpackage

// File: rtl/sdram_rw_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after i_ptr
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);
    always_comb begin
        o_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_req[(int'(i_ptr) + k) % N]) o_idx = IDX_W'((int'(i_ptr) + k) % N);
        end
    end
    assign o_valid = |i_req;
    assign o_grant = o_valid ? (N'(1) << o_idx) : '0;
endmodule

// File: rtl/sdram_rw_arbiter.sv
// sdram_rw_arbiter: round-robin share of the SDRAM wrapper command port between NPU requesters
module sdram_rw_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int SDRAM_W = 128,
    parameter int CNT_W   = ARB_CNT_W,
    parameter int ADDR_W  = ARB_ADDR_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          i_req_valid,
    input  logic [NUM_REQ-1:0]          i_req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]   i_req_addr,
    input  logic [NUM_REQ*CNT_W-1:0]    i_req_cnt,
    output logic [NUM_REQ-1:0]          o_req_grant,
    output logic [NUM_REQ-1:0]          o_req_done,
    output logic [NUM_REQ-1:0]          o_req_rd_valid,
    output logic [SDRAM_W-1:0]          o_req_rd_data,
    output logic [NUM_REQ-1:0]          o_req_wr_nxt,
    input  logic [NUM_REQ*SDRAM_W-1:0]  i_req_wr_data,
    output logic [ADDR_W-1:0]           o_rw_addr,
    output logic [CNT_W-1:0]            o_rw_cnt,
    output logic                        o_read_start,
    output logic                        o_write_start,
    input  logic                        i_rw_done,
    input  logic                        i_read_valid,
    input  logic [SDRAM_W-1:0]          i_read_data,
    input  logic                        i_write_nxt,
    output logic [SDRAM_W-1:0]          o_write_data
);
    localparam int IDX_W = $clog2(NUM_REQ);
    arb_state_e         r_state, w_next;
    logic [IDX_W-1:0]   r_ptr, r_owner, w_pick_idx;
    rw_cmd_t            r_cmd;
    logic [NUM_REQ-1:0] w_pick_oh, w_owner_oh;
    logic               w_any, w_busy_rd, w_busy_wr;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [CNT_W-1:0]   w_sel_cnt;

    rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .i_req   (i_req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_pick_oh),
        .o_idx   (w_pick_idx),
        .o_valid (w_any)
    );

    assign w_sel_addr = i_req_addr[w_pick_idx*ADDR_W +: ADDR_W];
    assign w_sel_cnt  = i_req_cnt[w_pick_idx*CNT_W +: CNT_W];

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = (w_sel_cnt == '0) ? DONE : ISSUE;
            ISSUE:   w_next = BUSY;
            BUSY:    if (i_rw_done) w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_cmd   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_any) begin
                r_owner <= w_pick_idx;
                r_cmd   <= '{addr: ARB_ADDR_W'(w_sel_addr), cnt: ARB_CNT_W'(w_sel_cnt),
                             write: i_req_write[w_pick_idx]};
            end
            if (r_state == DONE) r_ptr <= (int'(r_owner) == NUM_REQ - 1) ? '0 : r_owner + 1'b1;
        end
    end

    // grant is combinational in IDLE, so it is masked while reset is held
    assign o_req_grant    = (r_state == IDLE && rst_n) ? w_pick_oh : '0;
    assign w_owner_oh     = NUM_REQ'(1) << r_owner;
    assign w_busy_rd      = r_state == BUSY && r_cmd.write == DIR_READ;
    assign w_busy_wr      = r_state == BUSY && r_cmd.write == DIR_WRITE;
    assign o_req_done     = (r_state == DONE) ? w_owner_oh : '0;
    assign o_req_rd_valid = (w_busy_rd && i_read_valid) ? w_owner_oh : '0;
    assign o_req_wr_nxt   = (w_busy_wr && i_write_nxt) ? w_owner_oh : '0;
    assign o_req_rd_data  = i_read_data;
    assign o_write_data   = w_busy_wr ? i_req_wr_data[r_owner*SDRAM_W +: SDRAM_W] : '0;
    assign o_read_start   = r_state == ISSUE && r_cmd.write == DIR_READ;
    assign o_write_start  = r_state == ISSUE && r_cmd.write == DIR_WRITE;
    assign o_rw_addr      = ADDR_W'(r_cmd.addr);
    assign o_rw_cnt       = CNT_W'(r_cmd.cnt);
endmodule

// File: tb/tb_sdram_rw_arbiter.sv
// tb_sdram_rw_arbiter: directed self-checking bench for the SDRAM port arbiter
module tb_sdram_rw_arbiter;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_valid, req_write, req_grant, req_done, req_rd_valid, req_wr_nxt;
    logic [63:0]  req_addr;
    logic [21:0]  req_cnt;
    logic [255:0] req_wr_data;
    logic [127:0] req_rd_data, read_data, write_data;
    logic [31:0]  rw_addr;
    logic [10:0]  rw_cnt;
    logic         read_start, write_start, rw_done, read_valid, write_nxt;
    int           n_tests = 0;
    int           n_fail = 0;

    sdram_rw_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(req_valid), .i_req_write(req_write), .i_req_addr(req_addr), .i_req_cnt(req_cnt),
        .o_req_grant(req_grant), .o_req_done(req_done), .o_req_rd_valid(req_rd_valid),
        .o_req_rd_data(req_rd_data), .o_req_wr_nxt(req_wr_nxt), .i_req_wr_data(req_wr_data),
        .o_rw_addr(rw_addr), .o_rw_cnt(rw_cnt), .o_read_start(read_start), .o_write_start(write_start),
        .i_rw_done(rw_done), .i_read_valid(read_valid), .i_read_data(read_data),
        .i_write_nxt(write_nxt), .o_write_data(write_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 2'b10; req_write = '0; req_addr = '0; req_cnt = '0;
        req_wr_data = '0; rw_done = 0; read_valid = 0; read_data = '0; write_nxt = 0;
        cyc(); cyc();
        chk("rst_grant", req_grant, 0);
        chk("rst_done", req_done, 0);
        chk("rst_starts", {read_start, write_start}, 0);
        chk("rst_addr_cnt", {rw_addr, rw_cnt}, 0);
        chk("rst_wdata", write_data, 0);
        req_valid = 0; rst_n = 1'b1;
        cyc();
        // single read from requester 0
        req_valid = 2'b01; req_addr[31:0] = 32'h3000_0000; req_cnt[10:0] = 11'd4;
        #1 chk("rd_grant", req_grant, 2'b01);
        chk("rd_nostart_idle", read_start, 0);
        cyc();
        req_valid = 0;
        #1 chk("rd_start", {read_start, write_start}, 2'b10);
        chk("rd_grant_off", req_grant, 0);
        chk("rd_addr", rw_addr, 32'h3000_0000);
        chk("rd_cnt", rw_cnt, 4);
        cyc();
        chk("rd_start_once", read_start, 0);
        for (int i = 0; i < 4; i++) begin
            read_valid = 1; read_data = 128'hA0 + 128'(i);
            #1 chk("rd_valid", req_rd_valid, 2'b01);
            chk("rd_data", req_rd_data, 128'hA0 + 128'(i));
            cyc();
        end
        read_valid = 0; rw_done = 1;
        #1 chk("rd_addr_hold", {rw_addr, rw_cnt}, {32'h3000_0000, 11'd4});
        chk("rd_done_early", req_done, 0);
        cyc();
        rw_done = 0;
        chk("rd_done", req_done, 2'b01);
        cyc();
        chk("rd_done_pulse", req_done, 0);
        // single write from requester 1, with a stray read_valid on the first beat
        req_valid = 2'b10; req_write = 2'b10; req_addr[63:32] = 32'h3000_0400; req_cnt[21:11] = 11'd3;
        #1 chk("wr_grant", req_grant, 2'b10);
        cyc();
        req_valid = 0;
        #1 chk("wr_start", {read_start, write_start}, 2'b01);
        chk("wr_addr", rw_addr, 32'h3000_0400);
        chk("wr_cnt", rw_cnt, 3);
        chk("wr_data_issue", write_data, 0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            req_wr_data[255:128] = 128'hB0 + 128'(i); write_nxt = 1; read_valid = (i == 0);
            #1 chk("wr_data", write_data, 128'hB0 + 128'(i));
            chk("wr_nxt", req_wr_nxt, 2'b10);
            chk("wr_stray_rdv", req_rd_valid, 0);
            cyc();
        end
        write_nxt = 0; read_valid = 0; rw_done = 1;
        cyc();
        rw_done = 0;
        chk("wr_done", req_done, 2'b10);
        chk("wr_data_done", write_data, 0);
        cyc();
        // stray strobes in IDLE
        write_nxt = 1; read_valid = 1; rw_done = 1; req_write = 0;
        #1 chk("idle_stray_nxt", req_wr_nxt, 0);
        chk("idle_stray_rdv", req_rd_valid, 0);
        cyc();
        chk("idle_stray_state", {read_start, write_start, req_done}, 0);
        cyc();
        chk("idle_stray_state2", {read_start, write_start, req_done}, 0);
        write_nxt = 0; read_valid = 0; rw_done = 0;
        // zero count on requester 0
        req_valid = 2'b01; req_cnt[10:0] = 0;
        #1 chk("zc_grant", req_grant, 2'b01);
        cyc();
        req_valid = 0;
        chk("zc_done", req_done, 2'b01);
        chk("zc_nostart", {read_start, write_start}, 0);
        cyc();
        chk("zc_idle", {read_start, write_start, req_done}, 0);
        // contention: pointer is now 1, so grants go 1,0,1,0
        req_cnt = {11'd1, 11'd1}; req_valid = 2'b11;
        for (int n = 0; n < 4; n++) begin
            #1 chk("ct_grant", req_grant, (n % 2 == 0) ? 2'b10 : 2'b01);
            chk("ct_gap", read_start, 0);
            cyc();
            chk("ct_start", read_start, 1);
            cyc();
            chk("ct_busy_nostart", {read_start, req_grant}, 0);
            read_valid = 1;
            #1 chk("ct_rdv", req_rd_valid, (n % 2 == 0) ? 2'b10 : 2'b01);
            cyc();
            read_valid = 0; rw_done = 1;
            cyc();
            rw_done = 0;
            chk("ct_done", req_done, (n % 2 == 0) ? 2'b10 : 2'b01);
            chk("ct_done_nostart", read_start, 0);
            if (n == 3) req_valid = 0;
            cyc();
        end
        // reset during an 8-beat read, at beat 2
        req_valid = 2'b01; req_cnt[10:0] = 11'd8; req_addr[31:0] = 32'h3000_1000;
        #1 chk("mr_grant", req_grant, 2'b01);
        cyc();
        req_valid = 0;
        cyc();
        read_valid = 1;
        cyc();
        #1 chk("mr_beat", req_rd_valid, 2'b01);
        rst_n = 0;
        #1 chk("mr_rdv", req_rd_valid, 0);
        chk("mr_addr_cnt", {rw_addr, rw_cnt}, 0);
        chk("mr_starts", {read_start, write_start, req_grant, req_done}, 0);
        cyc();
        read_valid = 0; rst_n = 1;
        cyc();
        req_valid = 2'b10; req_write = 2'b10; req_addr[63:32] = 32'h3000_0800; req_cnt[21:11] = 11'd2;
        #1 chk("ar_grant", req_grant, 2'b10);
        cyc();
        req_valid = 0;
        chk("ar_start", {read_start, write_start}, 2'b01);
        chk("ar_cnt", {rw_addr, rw_cnt}, {32'h3000_0800, 11'd2});
        cyc();
        write_nxt = 1;
        #1 chk("ar_nxt", req_wr_nxt, 2'b10);
        cyc();
        write_nxt = 0; rw_done = 1;
        cyc();
        rw_done = 0;
        chk("ar_done", req_done, 2'b10);
        cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
